data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Shares the single-port data memory (mem_data) between two requesters: port 0 (core load/store) and
//   port 1 (debug/loader DMA). Grant is decided in the same cycle so the single-cycle core never loses a cycle.
//   Starvation is bounded by a burst limit. Out-of-range accesses are masked and flagged.
//   Sits between core/loader and mem_data inside toplevel.
// PARAMETERS
//   p_WORD_LEN   16  data word width
//   p_ADDR_LEN   10  memory address width; valid range 0 .. 2**p_ADDR_LEN-1
//   p_MAX_BURST  4   max consecutive grants to one port while the other waits (>=1)
// PORTS
//   i_clk          in   1            clock; all state on rising edge
//   i_rst_n        in   1            asynchronous active-low reset
//   i_rK_req       in   1            port K (K=0,1) access request for this cycle
//   i_rK_wr_en     in   1            port K: 1=write, 0=read
//   i_rK_addr      in   16           port K word address
//   i_rK_wr_data   in   p_WORD_LEN   port K write data
//   o_rK_gnt       out  1            port K granted this cycle (combinational)
//   o_rK_rd_data   out  p_WORD_LEN   port K read data; valid when gnt & ~wr_en
//   o_mem_wr_en    out  1            to mem_data write enable
//   o_mem_addr     out  p_ADDR_LEN   to mem_data address
//   o_mem_wr_data  out  p_WORD_LEN   to mem_data write data
//   i_mem_rd_data  in   p_WORD_LEN   from mem_data, combinational read
//   i_err_clr      in   1            synchronous clear of o_oor_err
//   o_oor_err      out  1            sticky: a granted access had addr >= 2**p_ADDR_LEN
//   o_stall_cnt    out  16           saturating count of cycles a request was refused
// BEHAVIOUR
//   State: r_last (last owner, 0/1), r_burst (consecutive grants to r_last, saturates at p_MAX_BURST),
//     r_oor_err, r_stall_cnt. Reset value of all state is 0.
//   Grant (combinational, at most one gnt high):
//     - reset asserted: both gnt=0, o_mem_wr_en=0.
//     - only one port requesting: that port is granted.
//     - both requesting, r_burst<p_MAX_BURST: grant r_last.
//     - both requesting, r_burst==p_MAX_BURST: grant the other port.
//     - Port 0 wins the first conflict after reset (r_last=0, r_burst=0).
//   Update (clock edge):
//     - granted g==r_last: r_burst<=min(r_burst+1, p_MAX_BURST).
//     - granted g!=r_last: r_last<=g, r_burst<=1.
//     - no request: r_burst<=0, r_last unchanged.
//   Mem mux:
//     - o_mem_addr/o_mem_wr_data come from the granted port; port 0 when none is granted.
//     - o_mem_wr_en = gnt & wr_en & in_range.
//     - in_range = (addr < 2**p_ADDR_LEN), computed on the full 16-bit addr.
//   Read data:
//     - o_rK_rd_data = i_mem_rd_data when gnt_K & ~wr_en_K & in_range, else 0.
//     - Out-of-range reads return 0 and out-of-range writes are dropped.
//   o_oor_err:
//     - Set on any edge with a granted out-of-range access.
//     - i_err_clr clears it; if clear and a new error occur in the same cycle, set wins.
//   o_stall_cnt: +1 per edge on which a port has req=1 and gnt=0; saturates at 16'hFFFF; reset only by i_rst_n.
//   Latency: 0 cycles for grant and read data; writes land on the edge that ends the granted cycle.
//   Reset mid-operation: outputs drop immediately; the in-flight write is not performed; state returns to 0.
// TESTING
//   - Reset: i_rst_n=0 while both ports request a write -> both gnt=0, o_mem_wr_en=0, o_stall_cnt=0, o_oor_err=0.
//   - Single port: r1 writes 16'hBEEF to addr 5, then r1 reads addr 5 -> o_mem_wr_en=1 on the write cycle;
//     o_r1_rd_data=16'hBEEF on the read; r0_rd_data=0.
//   - Conflict, p_MAX_BURST=4, both req held 10 cycles -> grant order 0,0,0,0,1,1,1,1,0,0; o_stall_cnt=10.
//   - Out of range: r0 writes addr 1024 -> o_mem_wr_en=0, o_oor_err=1 next cycle;
//     r0 read of 1024 returns 0; i_err_clr -> o_oor_err=0.
//   - Idle gap: burst broken by one cycle with no request -> r_burst=0; next conflict grants r_last again for 4 cycles.
//   - Async reset mid-conflict: assert i_rst_n=0 between edges -> gnts drop immediately;
//     after release, the first conflict grants port 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 (core) and port 1 (loader DMA).
// Grant is combinational; a burst limit bounds starvation, and out-of-range accesses are masked and flagged.
module data_mem_arbiter #(
    parameter int p_WORD_LEN  = 16,
    parameter int p_ADDR_LEN  = 10,
    parameter int p_MAX_BURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_r0_req,
    input  logic                  i_r0_wr_en,
    input  logic [15:0]           i_r0_addr,
    input  logic [p_WORD_LEN-1:0] i_r0_wr_data,
    output logic                  o_r0_gnt,
    output logic [p_WORD_LEN-1:0] o_r0_rd_data,
    input  logic                  i_r1_req,
    input  logic                  i_r1_wr_en,
    input  logic [15:0]           i_r1_addr,
    input  logic [p_WORD_LEN-1:0] i_r1_wr_data,
    output logic                  o_r1_gnt,
    output logic [p_WORD_LEN-1:0] o_r1_rd_data,
    output logic                  o_mem_wr_en,
    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic [p_WORD_LEN-1:0] o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
    input  logic                  i_err_clr,
    output logic                  o_oor_err,
    output logic [15:0]           o_stall_cnt
);

    localparam int                 BURST_W    = $clog2(p_MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(p_MAX_BURST);
    localparam logic [16:0]        ADDR_LIMIT = 17'(2 ** p_ADDR_LEN);

    typedef enum logic {
        OWN_R0 = 1'b0,
        OWN_R1 = 1'b1
    } owner_t;

    owner_t             r_last, last_nxt, gnt_owner;
    logic [BURST_W-1:0] r_burst, burst_nxt;
    logic               r_oor_err, oor_nxt;
    logic [15:0]        r_stall_cnt, stall_nxt;

    logic in_range0, in_range1;
    logic gnt0, gnt1;
    logic oor_set, refused;

    // Range test uses the full 16-bit address; the extra bit keeps 2**p_ADDR_LEN representable.
    assign in_range0 = {1'b0, i_r0_addr} < ADDR_LIMIT;
    assign in_range1 = {1'b0, i_r1_addr} < ADDR_LIMIT;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_rst_n) begin
            if (i_r0_req && i_r1_req) begin
                // Stay with the last owner until its burst is used up, then hand over.
                if (r_burst < BURST_MAX) begin
                    gnt0 = (r_last == OWN_R0);
                    gnt1 = (r_last == OWN_R1);
                end else begin
                    gnt0 = (r_last == OWN_R1);
                    gnt1 = (r_last == OWN_R0);
                end
            end else begin
                gnt0 = i_r0_req;
                gnt1 = i_r1_req;
            end
        end
        gnt_owner = gnt1 ? OWN_R1 : OWN_R0;
    end

    assign o_r0_gnt      = gnt0;
    assign o_r1_gnt      = gnt1;
    assign o_mem_addr    = gnt1 ? i_r1_addr[p_ADDR_LEN-1:0] : i_r0_addr[p_ADDR_LEN-1:0];
    assign o_mem_wr_data = gnt1 ? i_r1_wr_data : i_r0_wr_data;
    assign o_mem_wr_en   = (gnt0 & i_r0_wr_en & in_range0) | (gnt1 & i_r1_wr_en & in_range1);
    assign o_r0_rd_data  = (gnt0 & ~i_r0_wr_en & in_range0) ? i_mem_rd_data : '0;
    assign o_r1_rd_data  = (gnt1 & ~i_r1_wr_en & in_range1) ? i_mem_rd_data : '0;

    assign oor_set = (gnt0 & ~in_range0) | (gnt1 & ~in_range1);
    assign refused = (i_r0_req & ~gnt0) | (i_r1_req & ~gnt1);

    always_comb begin
        last_nxt  = r_last;
        burst_nxt = r_burst;
        oor_nxt   = r_oor_err;
        stall_nxt = r_stall_cnt;
        if (gnt0 || gnt1) begin
            if (gnt_owner == r_last) begin
                if (r_burst < BURST_MAX) begin
                    burst_nxt = r_burst + 1'b1;
                end
            end else begin
                last_nxt  = gnt_owner;
                burst_nxt = BURST_W'(1);
            end
        end else begin
            burst_nxt = '0;
        end
        if (oor_set) begin
            oor_nxt = 1'b1;
        end else if (i_err_clr) begin
            oor_nxt = 1'b0;
        end
        if (refused && (r_stall_cnt != '1)) begin
            stall_nxt = r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last      <= OWN_R0;
            r_burst     <= '0;
            r_oor_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_last      <= last_nxt;
            r_burst     <= burst_nxt;
            r_oor_err   <= oor_nxt;
            r_stall_cnt <= stall_nxt;
        end
    end

    assign o_oor_err   = r_oor_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, async-reset sequence, and random traffic
// checked against a grant-history reference model with its own copy of memory.
module tb_data_mem_arbiter;

    localparam int P_MAX_BURST = 4;

    logic        clk, rst_n;
    logic        r0_req, r0_wr, r1_req, r1_wr, err_clr;
    logic [15:0] r0_addr, r0_wd, r1_addr, r1_wd;
    logic        r0_gnt, r1_gnt, mem_wr_en, oor_err;
    logic [15:0] r0_rd, r1_rd, mem_wd, mem_rd, stall_cnt;
    logic [9:0]  mem_addr;

    logic [15:0] mem     [1024];
    logic [15:0] ref_mem [1024];

    int          n_err = 0;
    int          n_chk = 0;
    int          hist[$];
    logic        m_oor;
    int          m_stall;

    typedef struct {
        logic        rst;
        logic        r0_req, r0_wr;
        logic [15:0] r0_addr, r0_wd;
        logic        r1_req, r1_wr;
        logic [15:0] r1_addr, r1_wd;
        logic        clr;
        logic        g0, g1, wen;
        logic [9:0]  maddr;
        logic [15:0] rd0, rd1;
        logic        oor;
        logic [15:0] stall;
    } vec_t;

    vec_t tbl[$];

    data_mem_arbiter #(.p_WORD_LEN(16), .p_ADDR_LEN(10), .p_MAX_BURST(P_MAX_BURST)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_r0_req(r0_req), .i_r0_wr_en(r0_wr), .i_r0_addr(r0_addr), .i_r0_wr_data(r0_wd),
        .o_r0_gnt(r0_gnt), .o_r0_rd_data(r0_rd),
        .i_r1_req(r1_req), .i_r1_wr_en(r1_wr), .i_r1_addr(r1_addr), .i_r1_wr_data(r1_wd),
        .o_r1_gnt(r1_gnt), .o_r1_rd_data(r1_rd),
        .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wd),
        .i_mem_rd_data(mem_rd), .i_err_clr(err_clr), .o_oor_err(oor_err), .o_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory the DUT actually drives; ref_mem is the model's independent view.
    assign mem_rd = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic rst, logic r0q, logic r0w, logic [15:0] r0a, logic [15:0] r0d,
                                logic r1q, logic r1w, logic [15:0] r1a, logic [15:0] r1d, logic clr,
                                logic g0, logic g1, logic wen, logic [9:0] ma, logic [15:0] rd0,
                                logic [15:0] rd1, logic oor, logic [15:0] st);
        vec_t v;
        v.rst = rst; v.r0_req = r0q; v.r0_wr = r0w; v.r0_addr = r0a; v.r0_wd = r0d;
        v.r1_req = r1q; v.r1_wr = r1w; v.r1_addr = r1a; v.r1_wd = r1d; v.clr = clr;
        v.g0 = g0; v.g1 = g1; v.wen = wen; v.maddr = ma; v.rd0 = rd0; v.rd1 = rd1;
        v.oor = oor; v.stall = st;
        return v;
    endfunction

    // Owner = port of the most recent grant (0 if none); run = trailing grants to it with no idle cycle.
    function automatic void owner_run(output int owner, output int run);
        owner = 0;
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] >= 0) begin
                owner = hist[i];
                break;
            end
        end
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == owner) run++;
            else break;
        end
    endfunction

    task automatic set_idle();
        r0_req = 0; r0_wr = 0; r0_addr = 0; r0_wd = 0;
        r1_req = 0; r1_wr = 0; r1_addr = 0; r1_wd = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        set_idle();
        #2 rst_n = 1'b0;
        hist.delete();
        m_oor = 1'b0;
        m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input vec_t v, input bit from_table);
        int          ow, run, g;
        bit          ir0, ir1, refused;
        vec_t        e;
        logic [15:0] exp_wd;
        r0_req = v.r0_req; r0_wr = v.r0_wr; r0_addr = v.r0_addr; r0_wd = v.r0_wd;
        r1_req = v.r1_req; r1_wr = v.r1_wr; r1_addr = v.r1_addr; r1_wd = v.r1_wd;
        err_clr = v.clr;
        ir0 = int'(v.r0_addr) < 1024;
        ir1 = int'(v.r1_addr) < 1024;
        owner_run(ow, run);
        if (v.r0_req && v.r1_req) g = (run >= P_MAX_BURST) ? 1 - ow : ow;
        else if (v.r0_req) g = 0;
        else if (v.r1_req) g = 1;
        else g = -1;
        exp_wd = (g == 1) ? v.r1_wd : v.r0_wd;
        e = v;
        if (!from_table) begin
            e.g0    = (g == 0);
            e.g1    = (g == 1);
            e.maddr = (g == 1) ? v.r1_addr[9:0] : v.r0_addr[9:0];
            e.wen   = (g == 0 && v.r0_wr && ir0) || (g == 1 && v.r1_wr && ir1);
            e.rd0   = (g == 0 && !v.r0_wr && ir0) ? ref_mem[v.r0_addr[9:0]] : 16'h0;
            e.rd1   = (g == 1 && !v.r1_wr && ir1) ? ref_mem[v.r1_addr[9:0]] : 16'h0;
            e.oor   = m_oor;
            e.stall = 16'(m_stall);
        end
        @(negedge clk);
        chk("gnt0", r0_gnt, e.g0);
        chk("gnt1", r1_gnt, e.g1);
        chk("mem_wr_en", mem_wr_en, e.wen);
        chk("mem_addr", mem_addr, e.maddr);
        chk("rd0", r0_rd, e.rd0);
        chk("rd1", r1_rd, e.rd1);
        chk("oor_err", oor_err, e.oor);
        chk("stall_cnt", stall_cnt, e.stall);
        if (!from_table) chk("mem_wr_data", mem_wd, exp_wd);
        // Advance the reference model by one clock edge.
        hist.push_back(g);
        if (g == 0 && !ir0) m_oor = 1'b1;
        else if (g == 1 && !ir1) m_oor = 1'b1;
        else if (v.clr) m_oor = 1'b0;
        refused = (v.r0_req && g != 0) || (v.r1_req && g != 1);
        if (refused && m_stall < 65535) m_stall++;
        if (g == 0 && v.r0_wr && ir0) ref_mem[v.r0_addr[9:0]] = v.r0_wd;
        if (g == 1 && v.r1_wr && ir1) ref_mem[v.r1_addr[9:0]] = v.r1_wd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_addr();
        int r = $urandom_range(0, 99);
        if (r < 75) return 16'($urandom_range(0, 31));
        if (r < 88) return 16'($urandom_range(1024, 1100));
        return 16'($urandom);
    endfunction

    initial begin
        vec_t v;
        int   k;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        hist.delete();
        m_oor = 1'b0;
        m_stall = 0;
        rst_n = 1'b1;
        r0_req = 1; r0_wr = 1; r0_addr = 16'd3; r0_wd = 16'h1111;
        r1_req = 1; r1_wr = 1; r1_addr = 16'd4; r1_wd = 16'h2222; err_clr = 0;

        // Reset held while both ports request writes.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gnt0", r0_gnt, 0);
        chk("rst_gnt1", r1_gnt, 0);
        chk("rst_wen", mem_wr_en, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_oor", oor_err, 0);
        @(negedge clk);
        chk("rst_stall_held", stall_cnt, 0);
        chk("rst_mem3", mem[3], 16'h0);
        set_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        tbl.push_back(mk(1, 0,0,16'd0,16'h0,    1,1,16'd5,16'hBEEF, 0, 0,1,1,10'd5, 16'h0,16'h0, 0,16'd0));
        tbl.push_back(mk(0, 0,0,16'd0,16'h0,    1,0,16'd5,16'h0,    0, 0,1,0,10'd5, 16'h0,16'hBEEF, 0,16'd0));
        tbl.push_back(mk(0, 1,1,16'd6,16'h1234, 0,0,16'd0,16'h0,    0, 1,0,1,10'd6, 16'h0,16'h0, 0,16'd0));
        tbl.push_back(mk(0, 0,0,16'd0,16'h0,    1,1,16'd0,16'hA5A5, 0, 0,1,1,10'd0, 16'h0,16'h0, 0,16'd0));
        for (k = 0; k < 10; k++) begin
            if (k >= 4 && k < 8)
                v = mk(k == 0, 1,0,16'd5,16'h0, 1,0,16'd6,16'h0, 0, 0,1,0,10'd6, 16'h0,16'h1234, 0,16'(k));
            else
                v = mk(k == 0, 1,0,16'd5,16'h0, 1,0,16'd6,16'h0, 0, 1,0,0,10'd5, 16'hBEEF,16'h0, 0,16'(k));
            tbl.push_back(v);
        end
        tbl.push_back(mk(0, 0,0,16'd0,16'h0, 0,0,16'd0,16'h0, 0, 0,0,0,10'd0, 16'h0,16'h0, 0,16'd10));
        for (k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1,0,16'd5,16'h0, 1,0,16'd6,16'h0, 0, 1,0,0,10'd5, 16'hBEEF,16'h0, 0,16'(10 + k)));
        tbl.push_back(mk(0, 1,0,16'd5,16'h0, 1,0,16'd6,16'h0, 0, 0,1,0,10'd6, 16'h0,16'h1234, 0,16'd14));
        tbl.push_back(mk(0, 1,1,16'd1024,16'h5555, 0,0,16'd0,16'h0, 0, 1,0,0,10'd0,   16'h0,16'h0, 0,16'd15));
        tbl.push_back(mk(0, 1,0,16'd1024,16'h0,    0,0,16'd0,16'h0, 0, 1,0,0,10'd0,   16'h0,16'h0, 1,16'd15));
        tbl.push_back(mk(0, 1,1,16'd2000,16'h7777, 0,0,16'd0,16'h0, 1, 1,0,0,10'd976, 16'h0,16'h0, 1,16'd15));
        tbl.push_back(mk(0, 0,0,16'd0,16'h0,       0,0,16'd0,16'h0, 1, 0,0,0,10'd0,   16'h0,16'h0, 1,16'd15));
        tbl.push_back(mk(0, 0,0,16'd0,16'h0,       0,0,16'd0,16'h0, 0, 0,0,0,10'd0,   16'h0,16'h0, 0,16'd15));
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            run_cycle(tbl[i], 1'b1);
        end

        // Async reset in the middle of a conflict, with port 1 owning and writing.
        do_reset();
        r0_req = 1; r0_wr = 0; r0_addr = 16'd5;
        r1_req = 1; r1_wr = 0; r1_addr = 16'd6;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("conf_gnt1", r1_gnt, (c >= 4));
            @(posedge clk);
            #1;
        end
        r1_wr = 1; r1_addr = 16'd9; r1_wd = 16'hDEAD;
        #1 chk("pre_rst_wen", mem_wr_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt0", r0_gnt, 0);
        chk("mid_rst_gnt1", r1_gnt, 0);
        chk("mid_rst_wen", mem_wr_en, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        @(posedge clk);
        #1 chk("no_inflight_write", mem[9], ref_mem[9]);
        r1_wr = 0; r1_addr = 16'd6;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt0", r0_gnt, 1);
        chk("post_rst_gnt1", r1_gnt, 0);
        @(posedge clk);
        #1;

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            v = mk(0, 0,0,16'd0,16'h0, 0,0,16'd0,16'h0, 0, 0,0,0,10'd0, 16'h0,16'h0, 0,16'd0);
            v.r0_req  = ($urandom_range(0, 9) < 7);
            v.r0_wr   = 1'($urandom_range(0, 1));
            v.r0_addr = rnd_addr();
            v.r0_wd   = 16'($urandom);
            v.r1_req  = ($urandom_range(0, 9) < 7);
            v.r1_wr   = 1'($urandom_range(0, 1));
            v.r1_addr = rnd_addr();
            v.r1_wd   = 16'($urandom);
            v.clr     = ($urandom_range(0, 9) == 0);
            run_cycle(v, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
